collision_monitor: RTL and testbench
====================================

Name: collision_monitor

Overview:
- Frame-rate game-state block directly downstream of the moving-obstacle generator.
- Consumes the obstacle bounding box (x1/x2/y1/y2) and the player bounding box, both in 640x480 pixel space.
- Tests for overlap once per `animate` tick and runs the play/hit/game-over state machine.
- Produces lives, score, an obstacle re-launch pulse and a run enable that gates `animate` to the movers.

Parameters:
- LIVES, 3: lives loaded at game start; range 1..7.
- INVULN_FRAMES, 60: animate ticks of invulnerability after a hit.
- MAX_SCORE, 9999: score saturation value.
- SCORE_W, 14: score width; must satisfy 2^SCORE_W > MAX_SCORE.

Ports:
- clk  in  1  system pixel clock
- reset  in  1  asynchronous, active-high; clears all state
- animate  in  1  one-cycle frame tick, shared with the movers
- start  in  1  level; sampled only in IDLE and OVER
- px1, px2, py1, py2  in  12 each  player box, inclusive, unsigned, x1<=x2, y1<=y2
- ox1, ox2, oy1, oy2  in  12 each  obstacle box, same conventions
- run  out  1  high in RUN and HIT; ANDed with `animate` upstream of the movers
- obstacle_rst  out  1  one-cycle pulse; drives the obstacle's `reset`
- hit  out  1  high while in HIT (renderer flashes the player)
- game_over  out  1  high in OVER
- lives  out  3  remaining lives
- score  out  SCORE_W  frames survived, saturating

Behaviour:
- Reset values (asynchronous): state=IDLE, run=0, obstacle_rst=0, hit=0, game_over=0, lives=LIVES, score=0, invuln counter=0. Reset asserted mid-game aborts immediately with no pulse on obstacle_rst.
- Overlap is combinational on the current inputs, inclusive on all edges: (px1<=ox2)&&(ox1<=px2)&&(py1<=oy2)&&(oy1<=py2). Comparisons are 12-bit unsigned; no sign extension. Boxes touching on a single pixel column or row count as a hit.
- Every state, score and lives update happens only on a clock edge where animate=1, except start handling in IDLE/OVER.
- States:
  - IDLE: run=0. On start=1 -> RUN next edge: lives=LIVES, score=0, one-cycle obstacle_rst pulse.
  - RUN: run=1. On animate with overlap:
    - lives>1: lives-=1, invuln=INVULN_FRAMES-1, obstacle_rst pulses, -> HIT.
    - lives==1: lives=0, -> OVER.
    - On animate without overlap: score+=1.
  - HIT: hit=1, run=1. Overlap is ignored. Each animate: score+=1 and invuln-=1. On the animate edge with invuln==0 -> RUN. The HIT stay is exactly INVULN_FRAMES ticks.
  - OVER: run=0, game_over=1. Score and lives are frozen. On start=1 -> RUN with the same initialisation as from IDLE.
- Score saturates at MAX_SCORE and never wraps. It does not increment on the tick that enters OVER, nor on the tick that causes a hit.
- obstacle_rst asserts the cycle after the triggering edge and lasts exactly one cycle. It never asserts outside the IDLE/OVER->RUN and RUN->HIT transitions.
- start and animate on the same edge in IDLE/OVER: start wins; that tick is not scored.
- start held high during RUN or HIT is ignored. A level held through OVER restarts on the first edge.
- Latency: overlap to lives/state change is 1 edge (the animate edge). All outputs are registered.

Decomposition:
- Shared game package holds:
  - state enum {IDLE, RUN, HIT, OVER};
  - SCREEN_W=640, SCREEN_H=480, COORD_W=12;
  - a box type of four COORD_W fields.
- One sub-module, `box_overlap`: purely combinational inclusive AABB test, two boxes in, 1 bit out. Reused later for player/ground and projectile checks.

Test Plan:
- Reset, then start=1 for one cycle -> obstacle_rst pulse 1 cycle; run=1, lives=3, score=0.
- Disjoint boxes (player 100..120, obstacle 300..320), 10 animate ticks -> score=10, lives=3, state RUN.
- Edge touch (px2=200, ox1=200, y ranges overlap) on an animate tick -> lives=2, hit=1, obstacle_rst pulse. Boxes held overlapping for 60 ticks -> lives stays 2; hit drops on tick 60.
- Third hit from lives=1 -> lives=0, game_over=1, run=0. Score unchanged on that tick; further animate ticks leave score frozen.
- Force score to 9998, run 5 clear ticks -> score=9999 and holds.
- Assert reset asynchronously mid-HIT (between clock edges) -> all outputs at reset values immediately; no obstacle_rst pulse. start with animate in OVER -> RUN, score=0.

Source files
------------

// File: rtl/collision_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : collision_monitor_pkg
// Purpose  : Shared game types: screen geometry, state encoding, box record.
// Revision : 1.0 - initial release
// ============================================================================
package collision_monitor_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 12;

  // Game-level state; two bits cover all four states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } game_state_e;

  // Inclusive, unsigned bounding box in pixel space (x1<=x2, y1<=y2)
  typedef struct packed {
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] y2;
  } box_t;

endpackage
`default_nettype wire

// File: rtl/collision_monitor_box_overlap.sv
`default_nettype none
// ============================================================================
// Module   : box_overlap
// Purpose  : Combinational inclusive axis-aligned bounding-box overlap test.
//            Boxes sharing a single pixel row or column count as overlapping.
// Revision : 1.0 - initial release
// ============================================================================
module box_overlap
  import collision_monitor_pkg::*;
(
  input  box_t a,
  input  box_t b,
  output logic overlap
);

  // Unsigned 12-bit compares on every edge, inclusive so touching boxes hit
  assign overlap = (a.x1 <= b.x2) && (b.x1 <= a.x2) &&
                   (a.y1 <= b.y2) && (b.y1 <= a.y2);

endmodule
`default_nettype wire

// File: rtl/collision_monitor.sv
`default_nettype none
// ============================================================================
// Module   : collision_monitor
// Purpose  : Per-frame player/obstacle collision check and the play / hit /
//            game-over state machine. Tracks lives and a saturating score,
//            re-launches the obstacle and gates the movers via run.
// Revision : 1.0 - initial release
// ============================================================================
module collision_monitor
  import collision_monitor_pkg::*;
#(
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int MAX_SCORE     = 9999,
  parameter int SCORE_W       = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               animate,
  input  logic               start,
  input  logic [11:0]        px1,
  input  logic [11:0]        px2,
  input  logic [11:0]        py1,
  input  logic [11:0]        py2,
  input  logic [11:0]        ox1,
  input  logic [11:0]        ox2,
  input  logic [11:0]        oy1,
  input  logic [11:0]        oy2,
  output logic               run,
  output logic               obstacle_rst,
  output logic               hit,
  output logic               game_over,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score
);

  // Counter only needs to hold INVULN_FRAMES-1
  localparam int                 INV_W      = (INVULN_FRAMES > 2) ? $clog2(INVULN_FRAMES) : 1;
  localparam logic [INV_W-1:0]   INV_LOAD   = INV_W'(INVULN_FRAMES - 1);
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(MAX_SCORE);

  game_state_e        state_q, state_d;
  logic [2:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [INV_W-1:0]   invuln_q, invuln_d;
  logic               obstacle_rst_q, obstacle_rst_d;

  box_t               player_box;
  box_t               obstacle_box;
  logic               overlap;
  logic [SCORE_W-1:0] score_inc;

  assign player_box   = '{x1: px1, x2: px2, y1: py1, y2: py2};
  assign obstacle_box = '{x1: ox1, x2: ox2, y1: oy1, y2: oy2};

  box_overlap u_box_overlap (
    .a       (player_box),
    .b       (obstacle_box),
    .overlap (overlap)
  );

  // Score one step up, pinned at the saturation value
  assign score_inc = (score_q >= SCORE_MAX) ? SCORE_MAX : score_q + 1'b1;

  // State register plus all game counters; reset aborts with no pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      lives_q        <= LIVES_INIT;
      score_q        <= '0;
      invuln_q       <= '0;
      obstacle_rst_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      score_q        <= score_d;
      invuln_q       <= invuln_d;
      obstacle_rst_q <= obstacle_rst_d;
    end
  end

  // Next-state and counter updates; only start is honoured off the animate tick
  always_comb begin
    state_d        = state_q;
    lives_d        = lives_q;
    score_d        = score_q;
    invuln_d       = invuln_q;
    obstacle_rst_d = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        // start wins over a coincident animate; that tick is not scored
        if (start) begin
          state_d        = RUN;
          lives_d        = LIVES_INIT;
          score_d        = '0;
          obstacle_rst_d = 1'b1;
        end
      end
      RUN: begin
        if (animate) begin
          if (overlap) begin
            if (lives_q > 3'd1) begin
              lives_d        = lives_q - 3'd1;
              invuln_d       = INV_LOAD;
              obstacle_rst_d = 1'b1;
              state_d        = HIT;
            end else begin
              lives_d = 3'd0;
              state_d = OVER;
            end
          end else begin
            score_d = score_inc;
          end
        end
      end
      HIT: begin
        // Overlap ignored; the counter was loaded with N-1 so the stay is N ticks
        if (animate) begin
          score_d = score_inc;
          if (invuln_q == '0) begin
            state_d = RUN;
          end else begin
            invuln_d = invuln_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    run       = (state_q == RUN) || (state_q == HIT);
    hit       = (state_q == HIT);
    game_over = (state_q == OVER);
  end

  assign obstacle_rst = obstacle_rst_q;
  assign lives        = lives_q;
  assign score        = score_q;

endmodule
`default_nettype wire

// File: tb/tb_collision_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_collision_monitor
// Purpose  : Self-checking bench for collision_monitor: a vector table for the
//            opening play sequence plus a reference model feeding a queue of
//            expected outputs for the longer hit / game-over / saturation runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_collision_monitor;
  import collision_monitor_pkg::*;

  localparam int LIVES = 3;
  localparam int INV   = 60;
  localparam int MAXS  = 9999;
  localparam int SW    = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          animate = 1'b0;
  logic          start = 1'b0;
  box_t          pb, ob;
  logic [11:0]   px1, px2, py1, py2, ox1, ox2, oy1, oy2;
  logic          run, obstacle_rst, hit, game_over;
  logic [2:0]    lives;
  logic [SW-1:0] score;

  assign px1 = pb.x1;
  assign px2 = pb.x2;
  assign py1 = pb.y1;
  assign py2 = pb.y2;
  assign ox1 = ob.x1;
  assign ox2 = ob.x2;
  assign oy1 = ob.y1;
  assign oy2 = ob.y2;

  collision_monitor #(
    .LIVES(LIVES), .INVULN_FRAMES(INV), .MAX_SCORE(MAXS), .SCORE_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .animate(animate), .start(start),
    .px1(px1), .px2(px2), .py1(py1), .py2(py2),
    .ox1(ox1), .ox2(ox2), .oy1(oy1), .oy2(oy2),
    .run(run), .obstacle_rst(obstacle_rst), .hit(hit), .game_over(game_over),
    .lives(lives), .score(score)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic anim;
    logic st;
    box_t p;
    box_t o;
    logic e_run;
    logic e_orst;
    logic e_hit;
    logic e_over;
    int   e_lives;
    int   e_score;
  } vec_t;

  typedef struct {
    logic run;
    logic orst;
    logic hit;
    logic over;
    int   lives;
    int   score;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  game_state_e m_state;
  int          m_lives, m_score, m_inv;
  logic        m_orst;

  function automatic box_t mk(input int x1, input int x2, input int y1, input int y2);
    box_t b;
    b.x1 = 12'(x1); b.x2 = 12'(x2); b.y1 = 12'(y1); b.y2 = 12'(y2);
    return b;
  endfunction

  function automatic logic touching(input box_t a, input box_t b);
    return (a.x1 <= b.x2) && (b.x1 <= a.x2) && (a.y1 <= b.y2) && (b.y1 <= a.y2);
  endfunction

  function automatic void model_reset();
    m_state = IDLE; m_lives = LIVES; m_score = 0; m_inv = 0; m_orst = 1'b0;
  endfunction

  function automatic void model_edge(input logic anim, input logic st, input logic ov);
    m_orst = 1'b0;
    case (m_state)
      IDLE, OVER: if (st) begin
        m_state = RUN; m_lives = LIVES; m_score = 0; m_orst = 1'b1;
      end
      RUN: if (anim) begin
        if (ov) begin
          if (m_lives > 1) begin
            m_lives = m_lives - 1; m_inv = INV - 1; m_orst = 1'b1; m_state = HIT;
          end else begin
            m_lives = 0; m_state = OVER;
          end
        end else if (m_score < MAXS) begin
          m_score = m_score + 1;
        end
      end
      HIT: if (anim) begin
        if (m_score < MAXS) m_score = m_score + 1;
        if (m_inv == 0) m_state = RUN;
        else m_inv = m_inv - 1;
      end
      default: ;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.run   = (m_state == RUN) || (m_state == HIT);
    e.hit   = (m_state == HIT);
    e.over  = (m_state == OVER);
    e.orst  = m_orst;
    e.lives = m_lives;
    e.score = m_score;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_dut(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, ".scoreboard_empty"}, 1, 0);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, ".run"},          int'(run),          int'(e.run));
    chk({tag, ".obstacle_rst"}, int'(obstacle_rst), int'(e.orst));
    chk({tag, ".hit"},          int'(hit),          int'(e.hit));
    chk({tag, ".game_over"},    int'(game_over),    int'(e.over));
    chk({tag, ".lives"},        int'(lives),        e.lives);
    chk({tag, ".score"},        int'(score),        e.score);
  endtask

  // One clock: drive at negedge, model the edge, compare 1 time unit after it
  task automatic step(input logic anim, input logic st, input string tag);
    @(negedge clk);
    animate = anim;
    start   = st;
    model_edge(anim, st, touching(pb, ob));
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    compare_dut(tag);
  endtask

  task automatic add_vec(input logic anim, input logic st, input box_t p, input box_t o,
                         input logic r, input logic orst, input logic h, input logic ov,
                         input int lv, input int sc);
    vec_t v;
    v.anim = anim; v.st = st; v.p = p; v.o = o;
    v.e_run = r; v.e_orst = orst; v.e_hit = h; v.e_over = ov;
    v.e_lives = lv; v.e_score = sc;
    vecs.push_back(v);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".run"},          int'(run),          0);
    chk({tag, ".obstacle_rst"}, int'(obstacle_rst), 0);
    chk({tag, ".hit"},          int'(hit),          0);
    chk({tag, ".game_over"},    int'(game_over),    0);
    chk({tag, ".lives"},        int'(lives),        LIVES);
    chk({tag, ".score"},        int'(score),        0);
  endtask

  initial begin
    box_t p_far, o_far, p_adj, o_edge, p_touch, p_yt, o_yt;
    p_far   = mk(100, 120, 100, 120);
    o_far   = mk(300, 320, 100, 120);
    p_adj   = mk(180, 199, 100, 120);
    o_edge  = mk(200, 220, 100, 120);
    p_touch = mk(180, 200, 100, 120);
    p_yt    = mk(100, 120, 100, 120);
    o_yt    = mk(110, 130, 120, 140);

    // Opening sequence: idle ignores animate, start, 10 clear ticks, near miss, edge hit
    add_vec(1, 0, p_far, o_far, 0, 0, 0, 0, 3, 0);
    add_vec(0, 1, p_far, o_far, 1, 1, 0, 0, 3, 0);
    add_vec(0, 0, p_far, o_far, 1, 0, 0, 0, 3, 0);
    for (int i = 1; i <= 10; i++) add_vec(1, 0, p_far, o_far, 1, 0, 0, 0, 3, i);
    add_vec(1, 0, p_adj,   o_edge, 1, 0, 0, 0, 3, 11);
    add_vec(1, 0, p_touch, o_edge, 1, 1, 1, 0, 2, 11);
    add_vec(0, 0, p_touch, o_edge, 1, 0, 1, 0, 2, 11);

    pb = p_far;
    ob = o_far;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      pb = vecs[i].p;
      ob = vecs[i].o;
      step(vecs[i].anim, vecs[i].st, tag);
      chk({tag, ".tbl_run"},   int'(run),          int'(vecs[i].e_run));
      chk({tag, ".tbl_orst"},  int'(obstacle_rst), int'(vecs[i].e_orst));
      chk({tag, ".tbl_hit"},   int'(hit),          int'(vecs[i].e_hit));
      chk({tag, ".tbl_over"},  int'(game_over),    int'(vecs[i].e_over));
      chk({tag, ".tbl_lives"}, int'(lives),        vecs[i].e_lives);
      chk({tag, ".tbl_score"}, int'(score),        vecs[i].e_score);
    end

    // Invulnerability: boxes stay overlapping; start held mid-HIT is ignored
    for (int k = 1; k <= INV; k++) begin
      step(1'b1, (k >= 5 && k <= 8), "hit_hold");
      if (k == INV - 1) chk("hit_tick59.hit", int'(hit), 1);
      if (k == INV)     chk("hit_tick60.hit", int'(hit), 0);
    end
    chk("after_hit.lives", int'(lives), 2);
    chk("after_hit.score", int'(score), 71);

    // Second hit on a shared pixel row
    pb = p_yt;
    ob = o_yt;
    step(1'b1, 1'b0, "row_touch");
    chk("row_touch.lives", int'(lives), 1);
    chk("row_touch.orst",  int'(obstacle_rst), 1);
    chk("row_touch.score", int'(score), 71);
    for (int k = 1; k <= INV; k++) step(1'b1, 1'b0, "hit2_hold");

    // Final hit: game over, score frozen
    step(1'b1, 1'b0, "fatal");
    chk("fatal.game_over", int'(game_over), 1);
    chk("fatal.run",       int'(run), 0);
    chk("fatal.lives",     int'(lives), 0);
    chk("fatal.score",     int'(score), 131);
    chk("fatal.orst",      int'(obstacle_rst), 0);
    repeat (3) step(1'b1, 1'b0, "over_frozen");
    chk("over_frozen.score", int'(score), 131);

    // start together with animate in OVER restarts without scoring
    step(1'b1, 1'b1, "restart");
    chk("restart.run",   int'(run), 1);
    chk("restart.score", int'(score), 0);
    chk("restart.orst",  int'(obstacle_rst), 1);

    // Saturation at MAX_SCORE
    pb = p_far;
    ob = o_far;
    for (int k = 0; k < MAXS + 3; k++) step(1'b1, 1'b0, "saturate");
    chk("saturate.score", int'(score), MAXS);

    // Hit while saturated, then asynchronous reset between clock edges
    pb = p_touch;
    ob = o_edge;
    step(1'b1, 1'b0, "sat_hit");
    step(1'b1, 1'b0, "sat_hit_hold");
    chk("sat_hit_hold.score", int'(score), MAXS);
    chk("sat_hit_hold.hit",   int'(hit), 1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_values("async_reset");
    @(posedge clk);
    #1;
    check_reset_values("reset_held");
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, "idle_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
